// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Operand select for one execute source; memory stage is younger so it wins.
  function automatic logic [1:0] fwd_sel(input logic       reg_wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       reg_wr_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (reg_wr_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_MEM;
    else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    else                                                 return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing signal bundle between the datapath and the controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D, rs2D;
  logic             useRs1D, useRs2D;
  logic [4:0]       rs1E, rs2E;
  logic [4:0]       rdE, rdM, rdW;
  logic             RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             PCsrcE;
  logic             dump_req;
  logic             dump_done;
  logic             StallF, StallD;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             dump_start;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Datapath side: supplies register/stage info, consumes control.
  modport master (
    output rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
           RegWriteM, RegWriteW, MemtoRegE, PCsrcE, dump_req, dump_done,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           dump_start, halted, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
           RegWriteM, RegWriteW, MemtoRegE, PCsrcE, dump_req, dump_done,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           dump_start, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational operand forwarding selects for the execute stage.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       RegWriteM,
  input  logic [4:0] rdM,
  input  logic       RegWriteW,
  input  logic [4:0] rdW,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  // Same priority rule for both operands.
  always_comb begin
    ForwardAE = fwd_sel(RegWriteM, rdM, RegWriteW, rdW, rs1E);
    ForwardBE = fwd_sel(RegWriteM, rdM, RegWriteW, rdW, rs2E);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall,
// branch flush, and the drain/dump/halt sequence.
// Optional macro PERF_CNT_EN builds saturating stall/flush counters;
// without it both counter outputs are tied to zero.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lu;
  logic            stall_f, stall_d, flush_d, flush_e, dump_start, halted;

  fwd_unit u_fwd (
    .RegWriteM (bus.RegWriteM),
    .rdM       (bus.rdM),
    .RegWriteW (bus.RegWriteW),
    .rdW       (bus.rdW),
    .rs1E      (bus.rs1E),
    .rs2E      (bus.rs2E),
    .ForwardAE (bus.ForwardAE),
    .ForwardBE (bus.ForwardBE)
  );

  // Load in execute feeding a source the decode instruction really reads.
  always_comb begin
    lu = bus.MemtoRegE && (bus.rdE != 5'd0) &&
         ((bus.useRs1D && (bus.rdE == bus.rs1D)) ||
          (bus.useRs2D && (bus.rdE == bus.rs2D)));
  end

  // State, pending-dump flag and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/flush outputs; branch beats load-use in RUN.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    dump_start = 1'b0;
    halted     = 1'b0;
    case (state_q)
      RUN: begin
        // The request counts in its own cycle so an idle pipe drains next edge.
        pend_d = pend_q | bus.dump_req;
        if (bus.PCsrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        if (pend_d && !bus.PCsrcE && !lu) begin
          state_d = DRAIN;
          pend_d  = 1'b0;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        // Only bubbles enter behind us, so a late branch needs no action.
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (cnt_q == '0) state_d = DUMP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DUMP: begin
        dump_start = 1'b1;
        stall_f    = 1'b1;
        flush_d    = 1'b1;
        if (bus.dump_done) state_d = HALT;
      end
      HALT: begin
        halted  = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.StallF     = stall_f;
  assign bus.StallD     = stall_d;
  assign bus.FlushD     = flush_d;
  assign bus.FlushE     = flush_e;
  assign bus.dump_start = dump_start;
  assign bus.halted     = halted;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counts; only RUN-state hazards are counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == RUN) begin
      if (bus.PCsrcE && !(&flush_cnt_q))     flush_cnt_d = flush_cnt_q + 1'b1;
      if (!bus.PCsrcE && lu && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
module tb_pipeline_ctrl;

`ifdef PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: StallF, StallD, FlushD, FlushE.
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE}, {28'd0, exp});
  endtask

  task automatic idle();
    bus.rs1D = 5'd0; bus.rs2D = 5'd0; bus.useRs1D = 1'b0; bus.useRs2D = 1'b0;
    bus.rs1E = 5'd0; bus.rs2E = 5'd0; bus.rdE = 5'd0; bus.rdM = 5'd0; bus.rdW = 5'd0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.MemtoRegE = 1'b0;
    bus.PCsrcE = 1'b0; bus.dump_req = 1'b0; bus.dump_done = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    chk_ctl("reset_ctl", 4'b0000);
    chk("reset_fwdA", {30'd0, bus.ForwardAE}, 32'd0);
    chk("reset_dump_start", {31'd0, bus.dump_start}, 32'd0);
    chk("reset_halted", {31'd0, bus.halted}, 32'd0);
    chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
    chk("reset_flush_cnt", bus.flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Forwarding priority and x0 exclusion.
    bus.rdM = 5'd5; bus.RegWriteM = 1'b1; bus.rdW = 5'd5; bus.RegWriteW = 1'b1;
    bus.rs1E = 5'd5; bus.rs2E = 5'd5;
    #1;
    chk("fwdA_mem", {30'd0, bus.ForwardAE}, 32'd2);
    chk("fwdB_mem", {30'd0, bus.ForwardBE}, 32'd2);
    bus.RegWriteM = 1'b0;
    #1;
    chk("fwdA_wb", {30'd0, bus.ForwardAE}, 32'd1);
    bus.rs2E = 5'd6;
    #1;
    chk("fwdB_rf", {30'd0, bus.ForwardBE}, 32'd0);
    bus.rdM = 5'd0; bus.rdW = 5'd0; bus.RegWriteM = 1'b1; bus.rs1E = 5'd0;
    #1;
    chk("fwdA_x0", {30'd0, bus.ForwardAE}, 32'd0);
    idle();

    // Load-use through rs2.
    bus.MemtoRegE = 1'b1; bus.rdE = 5'd7; bus.rs2D = 5'd7; bus.useRs2D = 1'b1;
    #1;
    chk_ctl("lu_rs2", 4'b1101);
    cyc();
    idle();
    #1;
    chk_ctl("lu_released", 4'b0000);
    chk("lu_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);
    bus.MemtoRegE = 1'b1; bus.rdE = 5'd7; bus.rs2D = 5'd7; bus.useRs2D = 1'b0;
    #1;
    chk_ctl("lu_unused_src", 4'b0000);
    bus.rdE = 5'd0; bus.rs1D = 5'd0; bus.useRs1D = 1'b1;
    #1;
    chk_ctl("lu_rd_x0", 4'b0000);
    cyc();
    idle();
    chk("no_lu_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);

    // Branch beats load-use.
    bus.MemtoRegE = 1'b1; bus.rdE = 5'd7; bus.rs1D = 5'd7; bus.useRs1D = 1'b1; bus.PCsrcE = 1'b1;
    #1;
    chk_ctl("br_over_lu", 4'b0011);
    cyc();
    idle();
    #1;
    chk("br_flush_cnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("br_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);

    // Dump in an idle pipe.
    bus.dump_req = 1'b1;
    #1;
    chk_ctl("dump_req_cycle", 4'b0000);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin bus.PCsrcE = 1'b1; bus.dump_req = 1'b1; end
      #1;
      chk_ctl($sformatf("drain_%0d", i), 4'b1010);
      chk($sformatf("drain_%0d_ds", i), {31'd0, bus.dump_start}, 32'd0);
      cyc();
      idle();
    end
    chk("dump_start_rise", {31'd0, bus.dump_start}, 32'd1);
    chk_ctl("dump_ctl", 4'b1010);
    chk("drain_br_ignored", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    cyc();
    cyc();
    chk("dump_start_hold", {31'd0, bus.dump_start}, 32'd1);
    cyc();
    bus.dump_done = 1'b1;
    #1;
    chk("dump_start_at_done", {31'd0, bus.dump_start}, 32'd1);
    chk("not_halted_yet", {31'd0, bus.halted}, 32'd0);
    cyc();
    idle();
    #1;
    chk("halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_ds_low", {31'd0, bus.dump_start}, 32'd0);
    chk_ctl("halt_ctl", 4'b1101);
    bus.dump_req = 1'b1;
    cyc();
    idle();
    cyc();
    chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
    chk_ctl("halt_ctl_sticky", 4'b1101);

    // Reset out of HALT.
    rst = 1'b0;
    #1;
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk_ctl("rst_ctl", 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("rst_flush_cnt", bus.flush_cnt, 32'd0);

    // dump_req coincident with a branch: drain starts one cycle late.
    bus.dump_req = 1'b1; bus.PCsrcE = 1'b1;
    #1;
    chk_ctl("dreq_br", 4'b0011);
    cyc();
    idle();
    #1;
    chk_ctl("dreq_br_held", 4'b0000);
    cyc();
    chk_ctl("dreq_br_drain", 4'b1010);
    chk("dreq_br_flush_cnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk_ctl("mid_drain_rst_ctl", 4'b0000);
    chk("mid_drain_rst_ds", {31'd0, bus.dump_start}, 32'd0);
    chk("mid_drain_rst_flush_cnt", bus.flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("post_rst_%0d_ds", i), {31'd0, bus.dump_start}, 32'd0);
      chk_ctl($sformatf("post_rst_%0d_ctl", i), 4'b0000);
    end

    // dump_req during load-use: held until the stall clears.
    bus.dump_req = 1'b1; bus.MemtoRegE = 1'b1; bus.rdE = 5'd3; bus.rs1D = 5'd3; bus.useRs1D = 1'b1;
    #1;
    chk_ctl("dreq_lu", 4'b1101);
    cyc();
    idle();
    #1;
    chk_ctl("dreq_lu_held", 4'b0000);
    chk("dreq_lu_stall_cnt", bus.stall_cnt, PERF ? 32'd1 : 32'd0);
    cyc();
    chk_ctl("dreq_lu_drain", 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage RV32I pipeline: fetch, decode, execute, memory, writeback. Each cycle it decides operand forwarding into execute, load-use stalls, and branch flushes. It also runs a dump sequence: on request it drains in-flight instructions, hands the data-memory dump to the memory stage, and parks the core in a halted state until reset.

## Interface
Parameters:
- DRAIN_CYCLES, 4: cycles spent in DRAIN so instructions in D/E/M/W retire before dump.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1D, rs2D  in  5  source registers of instruction in decode.
- useRs1D, useRs2D  in  1  decode instruction actually reads rs1/rs2.
- rs1E, rs2E  in  5  source registers of instruction in execute.
- rdE, rdM, rdW  in  5  destination registers in E/M/W.
- RegWriteM, RegWriteW  in  1  register write enables in M/W.
- MemtoRegE  in  1  instruction in E is a load.
- PCsrcE  in  1  branch/jump taken, resolved in E.
- dump_req  in  1  single-cycle dump request.
- dump_done  in  1  memory stage finished dump.
- StallF, StallD  out  1  hold PC / IF-ID register.
- FlushD, FlushE  out  1  bubble IF-ID / ID-EX register.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 writeback result, 10 ALUoutM.
- dump_start  out  1  drive memory-stage dump.
- halted  out  1  core parked.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWriteM && rdM!=0 && rdM==rs1E.
  - Else 01 if RegWriteW && rdW!=0 && rdW==rs1E.
  - Else 00.
  - ForwardBE: same rule using rs2E.
- Load-use (lu): MemtoRegE && rdE!=0 && ((useRs1D && rdE==rs1D) || (useRs2D && rdE==rs2D)).
  - Response: StallF=StallD=FlushE=1 for exactly one cycle.
- Branch: PCsrcE → FlushD=FlushE=1, StallF=StallD=0.
  - Branch has priority over lu when both are asserted in the same cycle.
- FSM states: RUN, DRAIN, DUMP, HALT.
  - RUN: hazard logic above. dump_req sets a sticky dump_pend. Leave for DRAIN on the first cycle with dump_pend && !PCsrcE && !lu, which clears dump_pend and loads drain counter = DRAIN_CYCLES-1.
  - DRAIN: StallF=1, FlushD=1, StallD=0; forwarding stays active. Counter decrements each cycle. At 0 → DUMP. PCsrcE is ignored (only bubbles follow).
  - DUMP: dump_start=1 (level), StallF=1, FlushD=1. On dump_done → HALT.
  - HALT: halted=1, StallF=StallD=1, FlushE=1. Exit only via reset.
- dump_req outside RUN is ignored.
- Reset (async, any state): state=RUN, dump_pend=0, counter=0. All outputs 0; stall_cnt=flush_cnt=0.

## Timing
- Forward/stall/flush outputs: 0-cycle latency from inputs, valid before the next rising edge.
- RUN→DRAIN entry: edge after the qualifying cycle.
- DRAIN lasts exactly DRAIN_CYCLES cycles. DUMP is entered on the following edge, and dump_start rises on that same edge.
- dump_done sampled in DUMP: HALT on the next edge, then dump_start=0 and halted=1.
- dump_done already high on DUMP's first cycle: one-cycle dump_start pulse.
- dump_req while lu or PCsrcE: held; DRAIN begins after both clear.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on each cycle lu causes a stall (RUN only).
  - flush_cnt increments on each cycle PCsrcE causes a flush (RUN only).
  - Both saturate at all-ones and clear on reset.
- Not defined: counters are not built; stall_cnt and flush_cnt are tied to 0. Port list is unchanged.

## Structure
- Package pipe_ctrl_pkg:
  - state enum: RUN=0, DRAIN=1, DUMP=2, HALT=3.
  - forwarding constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_unit: purely combinational ForwardAE/ForwardBE generation, instantiated once.
- FSM, drain counter, lu/branch priority and perf counters live in pipeline_ctrl.

## Test plan
- rdM=5, RegWriteM=1, rdW=5, RegWriteW=1, rs1E=5 → ForwardAE=10. rdM=0 with rs1E=0 → ForwardAE=00.
- MemtoRegE=1, rdE=7, rs2D=7, useRs2D=1 → StallF=StallD=FlushE=1 for one cycle. Same with useRs2D=0 → no stall.
- lu and PCsrcE in the same cycle → FlushD=FlushE=1, StallF=0; flush_cnt +1 and stall_cnt unchanged (PERF_CNT_EN).
- dump_req pulse in an idle pipe → exactly 4 DRAIN cycles with StallF=1, then dump_start=1. dump_done 3 cycles later → halted=1 next edge, dump_start=0.
- dump_req coincident with PCsrcE → DRAIN delayed one cycle. rst low mid-DRAIN → immediately RUN, all outputs 0, no dump_start.
